// File: rtl/mux_scan_nto1_pkg.sv
// ============================================================================
// mux_scan_pkg : shared state encoding and mode constants for mux_scan_nto1
// Rev 1.0
// ============================================================================
`default_nettype none

package mux_scan_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mux_scan_nto1_mux.sv
// ============================================================================
// mux_nto1 : combinational N_CH:1 channel selector, zero for out-of-range sel
// Rev 1.0
// ============================================================================
`default_nettype none

module mux_nto1
    import mux_scan_pkg::*;
#(
    parameter int N_CH  = 16,
    parameter int W     = 8,
    parameter int SEL_W = 4
) (
    input  logic [N_CH*W-1:0] d,
    input  logic [SEL_W-1:0]  sel,
    output logic [W-1:0]      y
);

    // Compare against every legal index so unused sel codes fall through to 0.
    always_comb begin
        y = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel == SEL_W'(k)) begin
                y = d[k*W +: W];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_scan_nto1.sv
// ============================================================================
// mux_scan_nto1 : registered N_CH-channel selector, direct or scan, valid/ready
// Rev 1.0
// ============================================================================
`default_nettype none

module mux_scan_nto1
    import mux_scan_pkg::*;
#(
    parameter  int N_CH  = 16,
    parameter  int W     = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH*W-1:0] d,
    input  logic [SEL_W-1:0]  sel,
    input  logic              mode,
    input  logic              req,
    output logic              req_ready,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [SEL_W-1:0] r_cnt;
    logic [SEL_W-1:0] w_cnt_nxt;
    logic [W-1:0]     w_data_nxt;
    logic [SEL_W-1:0] w_ch_nxt;
    logic             w_valid_nxt;
    logic             w_last_nxt;
    logic             w_slot_free;
    logic [SEL_W-1:0] w_mux_idx;
    logic [W-1:0]     w_mux_y;

    assign w_slot_free = !out_valid || out_ready;
    assign req_ready   = (r_state == IDLE) && w_slot_free;

    // r_cnt idles at 0, so a scan request in IDLE picks channel 0 through it.
    assign w_mux_idx = ((r_state == SCAN) || (mode == MODE_SCAN)) ? r_cnt : sel;

    mux_nto1 #(
        .N_CH  (N_CH),
        .W     (W),
        .SEL_W (SEL_W)
    ) u_mux (
        .d   (d),
        .sel (w_mux_idx),
        .y   (w_mux_y)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = out_data;
        w_ch_nxt    = out_ch;
        w_valid_nxt = out_valid;
        w_last_nxt  = out_last;

        if (w_slot_free) begin
            w_valid_nxt = 1'b0;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        w_valid_nxt = 1'b1;
                        w_data_nxt  = w_mux_y;
                        if (mode == MODE_DIRECT) begin
                            w_ch_nxt   = sel;
                            w_last_nxt = 1'b1;
                        end else begin
                            w_ch_nxt    = '0;
                            w_last_nxt  = 1'b0;
                            w_cnt_nxt   = SEL_W'(1);
                            w_state_nxt = SCAN;
                        end
                    end
                end
                SCAN: begin
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = w_mux_y;
                    w_ch_nxt    = r_cnt;
                    if (r_cnt == SEL_W'(N_CH - 1)) begin
                        w_last_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_last_nxt = 1'b0;
                        w_cnt_nxt  = r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            out_data  <= w_data_nxt;
            out_ch    <= w_ch_nxt;
            out_valid <= w_valid_nxt;
            out_last  <= w_last_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_nto1.sv
// ============================================================================
// tb_mux_scan_nto1 : 16- and 10-channel builds against a transaction model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mux_scan_nto1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req;
    logic         mode;
    logic         out_ready;
    logic [3:0]   sel;
    logic [127:0] d;

    logic [7:0] od16, od10;
    logic [3:0] oc16, oc10;
    logic       ov16, ov10, ol16, ol10, rr16, rr10;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mux_scan_nto1 #(.N_CH(16), .W(8)) dut16 (
        .clk(clk), .rst_n(rst_n), .d(d), .sel(sel), .mode(mode), .req(req),
        .req_ready(rr16), .out_data(od16), .out_ch(oc16), .out_valid(ov16),
        .out_ready(out_ready), .out_last(ol16)
    );

    mux_scan_nto1 #(.N_CH(10), .W(8)) dut10 (
        .clk(clk), .rst_n(rst_n), .d(d[79:0]), .sel(sel), .mode(mode), .req(req),
        .req_ready(rr10), .out_data(od10), .out_ch(oc10), .out_valid(ov10),
        .out_ready(out_ready), .out_last(ol10)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Model: a pending beat plus "channels still to emit" of the running scan.
    typedef struct {
        bit       valid;
        bit [7:0] data;
        int       ch;
        bit       last;
        int       pos;
        int       rem;
    } mdl_t;

    mdl_t m16, m10;

    function automatic mdl_t mreset();
        mdl_t r;
        r.valid = 1'b0; r.data = 8'h00; r.ch = 0; r.last = 1'b0; r.pos = 0; r.rem = 0;
        return r;
    endfunction

    function automatic mdl_t mstep(mdl_t m, int n, logic rq, logic md, logic [3:0] sl,
                                   logic ordy, logic [127:0] dd);
        mdl_t r;
        int   s;
        r = m;
        s = int'(sl);
        if (m.valid && !ordy) return r;
        if (m.rem > 0) begin
            r.data  = dd[m.pos*8 +: 8];
            r.ch    = m.pos;
            r.pos   = m.pos + 1;
            r.rem   = m.rem - 1;
            r.last  = (r.rem == 0);
            r.valid = 1'b1;
        end else if (rq) begin
            r.valid = 1'b1;
            if (!md) begin
                r.ch   = s;
                r.last = 1'b1;
                r.data = (s < n) ? dd[s*8 +: 8] : 8'h00;
            end else begin
                r.ch   = 0;
                r.data = dd[7:0];
                r.pos  = 1;
                r.rem  = n - 1;
                r.last = 1'b0;
            end
        end else begin
            r.valid = 1'b0;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m16 = mreset();
            m10 = mreset();
        end else begin
            m16 = mstep(m16, 16, req, mode, sel, out_ready, d);
            m10 = mstep(m10, 10, req, mode, sel, out_ready, d);
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("m16_valid", 32'(ov16), 32'(m16.valid));
            chk("m16_data",  32'(od16), 32'(m16.data));
            chk("m16_ch",    32'(oc16), 32'(m16.ch));
            chk("m16_last",  32'(ol16), 32'(m16.last));
            chk("m16_rdy",   32'(rr16), 32'((m16.rem == 0) && (!m16.valid || out_ready)));
            chk("m10_valid", 32'(ov10), 32'(m10.valid));
            chk("m10_data",  32'(od10), 32'(m10.data));
            chk("m10_ch",    32'(oc10), 32'(m10.ch));
            chk("m10_last",  32'(ol10), 32'(m10.last));
            chk("m10_rdy",   32'(rr10), 32'((m10.rem == 0) && (!m10.valid || out_ready)));
        end
    end

    typedef struct {
        logic       req;
        logic       mode;
        logic [3:0] sel;
        logic       ordy;
        logic       valid;
        logic [7:0] data;
        logic [3:0] ch;
        logic       last;
        logic       rr;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(logic rq, logic md, logic [3:0] sl, logic ordy, logic v,
                                logic [7:0] dt, logic [3:0] c, logic l, logic r);
        vec_t x;
        x.req = rq; x.mode = md; x.sel = sl; x.ordy = ordy;
        x.valid = v; x.data = dt; x.ch = c; x.last = l; x.rr = r;
        return x;
    endfunction

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic set_d();
        for (int k = 0; k < 16; k++) d[k*8 +: 8] = 8'(8'hA0 + k);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit   seen;
        int   beats, lasts, lastch;

        rst_n = 1'b0; req = 1'b0; mode = 1'b0; sel = 4'd0; out_ready = 1'b1;
        set_d();
        m16 = mreset();
        m10 = mreset();
        repeat (3) @(negedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        chk("rst_valid", 32'(ov16), 32'd0);
        chk("rst_data",  32'(od16), 32'd0);
        chk("rst_ch",    32'(oc16), 32'd0);
        chk("rst_last",  32'(ol16), 32'd0);
        chk("rst_rdy",   32'(rr16), 32'd1);

        // Direct sel=5, then one full 16-channel scan.
        tbl[0] = mk(1'b1, 1'b0, 4'd5, 1'b1, 1'b1, 8'hA5, 4'd5, 1'b1, 1'b1);
        tbl[1] = mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 8'hA5, 4'd5, 1'b1, 1'b1);
        tbl[2] = mk(1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 8'hA0, 4'd0, 1'b0, 1'b0);
        for (int k = 1; k < 16; k++)
            tbl[2+k] = mk(1'b0, 1'b1, 4'd9, 1'b1, 1'b1, 8'(8'hA0 + k), 4'(k), k == 15, k == 15);
        tbl[18] = mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 8'hAF, 4'd15, 1'b1, 1'b1);

        for (int i = 0; i < 19; i++) begin
            req = tbl[i].req; mode = tbl[i].mode; sel = tbl[i].sel; out_ready = tbl[i].ordy;
            nxt();
            chk($sformatf("tbl%0d_valid", i), 32'(ov16), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d_data", i),  32'(od16), 32'(tbl[i].data));
            chk($sformatf("tbl%0d_ch", i),    32'(oc16), 32'(tbl[i].ch));
            chk($sformatf("tbl%0d_last", i),  32'(ol16), 32'(tbl[i].last));
            chk($sformatf("tbl%0d_rdy", i),   32'(rr16), 32'(tbl[i].rr));
        end
        req = 1'b0;

        // Backpressure at ch 7 with d[7] changing underneath the held beat.
        req = 1'b1; mode = 1'b1;
        nxt();
        req = 1'b0;
        repeat (7) nxt();
        chk("bp_ch7", 32'(oc16), 32'd7);
        out_ready = 1'b0;
        d[7*8 +: 8] = 8'h55;
        for (int i = 0; i < 3; i++) begin
            nxt();
            chk("bp_hold_valid", 32'(ov16), 32'd1);
            chk("bp_hold_data",  32'(od16), 32'hA7);
            chk("bp_hold_ch",    32'(oc16), 32'd7);
        end
        out_ready = 1'b1;
        nxt();
        chk("bp_rel_data", 32'(od16), 32'hA8);
        chk("bp_rel_ch",   32'(oc16), 32'd8);
        set_d();
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            nxt();
            seen = ov16 && ol16;
        end
        chk("bp_end_timeout", 32'(seen), 32'd1);
        nxt();

        // Back-to-back scans with req held high.
        req = 1'b1; mode = 1'b1;
        for (int i = 0; i < 32; i++) begin
            nxt();
            chk("b2b_valid", 32'(ov16), 32'd1);
            chk("b2b_ch",    32'(oc16), 32'(i % 16));
            chk("b2b_last",  32'(ol16), 32'((i % 16) == 15));
            if (i == 31) req = 1'b0;
        end
        nxt();
        chk("b2b_drain", 32'(ov16), 32'd0);
        repeat (12) nxt();

        // Ten-channel build: out-of-range direct select and a short scan.
        req = 1'b1; mode = 1'b0; sel = 4'd12;
        nxt();
        chk("n10_oor_valid", 32'(ov10), 32'd1);
        chk("n10_oor_data",  32'(od10), 32'h00);
        chk("n10_oor_ch",    32'(oc10), 32'd12);
        chk("n10_oor_last",  32'(ol10), 32'd1);
        req = 1'b0;
        nxt();
        req = 1'b1; mode = 1'b1;
        beats = 0; lasts = 0; lastch = -1;
        for (int i = 0; i < 16; i++) begin
            nxt();
            if (i == 0) req = 1'b0;
            if (ov10) begin
                beats++;
                if (ol10) begin
                    lasts++;
                    lastch = int'(oc10);
                end
            end
        end
        chk("n10_beats",  32'(beats),  32'd10);
        chk("n10_lasts",  32'(lasts),  32'd1);
        chk("n10_lastch", 32'(lastch), 32'd9);
        repeat (2) nxt();

        // Asynchronous reset in the middle of a scan.
        req = 1'b1; mode = 1'b1;
        nxt();
        req = 1'b0;
        repeat (4) nxt();
        chk("rs_ch4", 32'(oc16), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_valid", 32'(ov16), 32'd0);
        chk("rs_data",  32'(od16), 32'd0);
        chk("rs_ch",    32'(oc16), 32'd0);
        chk("rs_last",  32'(ol16), 32'd0);
        repeat (2) nxt();
        rst_n = 1'b1;
        chk("rs_rdy", 32'(rr16), 32'd1);
        req = 1'b1; mode = 1'b1;
        nxt();
        req = 1'b0;
        chk("rs_fresh_ch",   32'(oc16), 32'd0);
        chk("rs_fresh_data", 32'(od16), 32'hA0);
        chk("rs_fresh_last", 32'(ol16), 32'd0);
        repeat (17) nxt();

        // Random traffic, checked every cycle by the model.
        for (int c = 0; c < 3000; c++) begin
            req       = 1'($urandom_range(0, 1));
            mode      = 1'($urandom_range(0, 1));
            sel       = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) d = {$urandom, $urandom, $urandom, $urandom};
            nxt();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
